// File: rtl/arcade_input_pkg.sv
// Shared types and default constants for the arcade input conditioning stage.
package arcade_input_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } coin_st_t;

    localparam int DEB_CYC_DEF  = 65535;
    localparam int COIN_ON_DEF  = 3;
    localparam int COIN_OFF_DEF = 3;
    localparam int QDEPTH_DEF   = 7;

endpackage

// File: rtl/input_debounce.sv
// One input channel: 2-flop synchroniser followed by a stable-state debouncer.
module input_debounce
    import arcade_input_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic stable_o
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYC - 1);

    logic [1:0]  sync_q;
    logic [15:0] cnt_q, cnt_d;
    logic        stable_q, stable_d;

    // The output only follows after DEB_CYC consecutive differing samples.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/arcade_input_cond.sv
// Per-player input conditioning: debounced buttons plus a frame-aligned coin
// pulse generator fed by a small saturating pending-coin queue.
module arcade_input_cond
    import arcade_input_pkg::*;
#(
    parameter int NBTN     = 8,
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int COIN_ON  = COIN_ON_DEF,
    parameter int COIN_OFF = COIN_OFF_DEF,
    parameter int QDEPTH   = QDEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vblank,
    input  logic [NBTN-1:0] btn_in,
    input  logic            coin_in,
    output logic [NBTN-1:0] btn_out,
    output logic            coin_out,
    output logic [3:0]      coin_pend,
    output logic            coin_drop
);

    localparam logic [3:0] ON_LAST  = 4'(COIN_ON - 1);
    localparam logic [3:0] OFF_LAST = 4'(COIN_OFF - 1);
    localparam logic [3:0] QMAX     = 4'(QDEPTH);

    logic [NBTN:0] raw, deb;
    assign raw = {coin_in, btn_in};

    for (genvar i = 0; i <= NBTN; i++) begin : g_ch
        input_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (raw[i]),
            .stable_o (deb[i])
        );
    end

    logic       vblank_q, coin_deb_q;
    coin_st_t   state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic [3:0] pend_q, pend_d;
    logic       coin_out_q, coin_out_d;
    logic       drop_q, drop_d;
    logic       ftick, coin_rise, deq;

    assign ftick     = vblank & ~vblank_q;
    assign coin_rise = deb[NBTN] & ~coin_deb_q;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        coin_out_d = coin_out_q;
        pend_d     = pend_q;
        drop_d     = 1'b0;
        deq        = 1'b0;
        case (state_q)
            IDLE: if (ftick && pend_q != 4'd0) begin
                state_d    = ON;
                coin_out_d = 1'b1;
                fcnt_d     = '0;
                deq        = 1'b1;
            end
            ON: if (ftick) begin
                if (fcnt_q == ON_LAST) begin
                    state_d    = OFF;
                    fcnt_d     = '0;
                    coin_out_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                end
            end
            OFF: if (ftick) begin
                if (fcnt_q == OFF_LAST) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                fcnt_d     = '0;
                coin_out_d = 1'b0;
            end
        endcase
        // An edge coinciding with a dequeue cancels out, even when saturated.
        if (coin_rise && !deq) begin
            if (pend_q == QMAX) drop_d = 1'b1;
            else                pend_d = pend_q + 4'd1;
        end else if (!coin_rise && deq) begin
            pend_d = pend_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q   <= 1'b0;
            coin_deb_q <= 1'b0;
            state_q    <= IDLE;
            fcnt_q     <= '0;
            pend_q     <= '0;
            coin_out_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            vblank_q   <= vblank;
            coin_deb_q <= deb[NBTN];
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            pend_q     <= pend_d;
            coin_out_q <= coin_out_d;
            drop_q     <= drop_d;
        end
    end

    assign btn_out   = deb[NBTN-1:0];
    assign coin_out  = coin_out_q;
    assign coin_pend = pend_q;
    assign coin_drop = drop_q;

endmodule

// File: tb/tb_arcade_input_cond.sv
// Bench for arcade_input_cond: directed stimulus, expected output-change events
// queued with their cycle stamps, and a negedge monitor that checks each change.
module tb_arcade_input_cond;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       vblank  = 1'b0;
    logic       coin_in = 1'b0;
    logic [7:0] btn_in  = 8'h00;
    logic [7:0] btn_out;
    logic       coin_out;
    logic [3:0] coin_pend;
    logic       coin_drop;

    arcade_input_cond #(
        .NBTN(8), .DEB_CYC(16), .COIN_ON(3), .COIN_OFF(3), .QDEPTH(7)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vblank    (vblank),
        .btn_in    (btn_in),
        .coin_in   (coin_in),
        .btn_out   (btn_out),
        .coin_out  (coin_out),
        .coin_pend (coin_pend),
        .coin_drop (coin_drop)
    );

    // ---------------- clock / reset / frame timing ----------------
    always #5 clk = ~clk;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // vblank rises on stamps where cyc%100 == 50, so pulse edges land on ...51
    logic vb_en = 1'b1;
    always @(posedge clk) begin
        #1;
        vblank = vb_en && ((cyc % 100) >= 50) && ((cyc % 100) < 60);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got cyc=%0d want finish", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    // event word: {kind[3:0], value[11:0], cycle[31:0]}
    // kind 1 = btn_out, 2 = coin_out, 3 = coin_pend, 4 = coin_drop
    logic [47:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic void expect_ev(input logic [3:0] k, input logic [11:0] v,
                                      input logic [31:0] c);
        exp_q.push_back({k, v, c});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic observe(input logic [3:0] k, input logic [11:0] v);
        logic [47:0] got, want;
        got = {k, v, cyc};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0h cyc=%0d want none",
                     got[47:44], got[43:32], got[31:0]);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL event: got kind=%0d val=%0h cyc=%0d want kind=%0d val=%0h cyc=%0d",
                         got[47:44], got[43:32], got[31:0],
                         want[47:44], want[43:32], want[31:0]);
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic       mon_en = 1'b0;
    logic [7:0] p_btn;
    logic       p_coin, p_drop;
    logic [3:0] p_pend;

    always @(negedge clk) begin
        if (mon_en) begin
            if (btn_out   !== p_btn)  observe(4'd1, {4'd0, btn_out});
            if (coin_out  !== p_coin) observe(4'd2, {11'd0, coin_out});
            if (coin_pend !== p_pend) observe(4'd3, {8'd0, coin_pend});
            if (coin_drop !== p_drop) observe(4'd4, {11'd0, coin_drop});
            p_btn  = btn_out;
            p_coin = coin_out;
            p_pend = coin_pend;
            p_drop = coin_drop;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int at, input int len);
        wait_cyc(at);
        coin_in = 1'b1;
        wait_cyc(at + len);
        coin_in = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        wait_cyc(2);
        chk("reset_btn_out",   {24'd0, btn_out},   32'd0);
        chk("reset_coin_out",  {31'd0, coin_out},  32'd0);
        chk("reset_coin_pend", {28'd0, coin_pend}, 32'd0);
        chk("reset_coin_drop", {31'd0, coin_drop}, 32'd0);
        wait_cyc(3);
        reset_n = 1'b1;
        p_btn = btn_out; p_coin = coin_out; p_pend = coin_pend; p_drop = coin_drop;
        mon_en = 1'b1;

        // 10-cycle glitch: no output change
        wait_cyc(10);  btn_in = 8'h08;
        wait_cyc(20);  btn_in = 8'h00;
        // clean steps: output follows 2 + 16 = 18 cycles later
        wait_cyc(50);  expect_ev(1, 12'h008, 68);  btn_in = 8'h08;
        wait_cyc(100); expect_ev(1, 12'h0A5, 118); btn_in = 8'hA5;
        wait_cyc(150); expect_ev(1, 12'h000, 168); btn_in = 8'h00;
        // 15 cycles high is one short; 16 cycles is just enough
        wait_cyc(200); btn_in = 8'h01;
        wait_cyc(215); btn_in = 8'h00;
        wait_cyc(250);
        expect_ev(1, 12'h001, 268);
        expect_ev(1, 12'h000, 284);
        btn_in = 8'h01;
        wait_cyc(266); btn_in = 8'h00;

        // single coin: queued at 319, pulse 351..651 (three frames)
        expect_ev(3, 12'd1, 319);
        expect_ev(2, 12'd1, 351);
        expect_ev(3, 12'd0, 351);
        expect_ev(2, 12'd0, 651);
        press(300, 30);

        // burst of three inside one frame; OFF leaves on its third tick, so the
        // next pulse starts one tick later (low gap of four frame periods)
        expect_ev(3, 12'd1, 974);
        expect_ev(3, 12'd2, 1008);
        expect_ev(3, 12'd3, 1042);
        expect_ev(2, 12'd1, 1051); expect_ev(3, 12'd2, 1051);
        expect_ev(2, 12'd0, 1351);
        expect_ev(2, 12'd1, 1751); expect_ev(3, 12'd1, 1751);
        expect_ev(2, 12'd0, 2051);
        expect_ev(2, 12'd1, 2451); expect_ev(3, 12'd0, 2451);
        expect_ev(2, 12'd0, 2751);
        press(955, 17);
        press(989, 17);
        press(1023, 17);

        // saturation with vblank held low: 9 presses, 7 queued, 2 drops
        wait_cyc(3060); vb_en = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 7) begin
                expect_ev(3, 12'(k + 1), 32'(3119 + 34 * k));
            end else begin
                expect_ev(4, 12'd1, 32'(3119 + 34 * k));
                expect_ev(4, 12'd0, 32'(3120 + 34 * k));
            end
            press(3100 + 34 * k, 17);
        end

        // edge at saturation on the dequeue tick: pend stays 7, no drop
        wait_cyc(3460); vb_en = 1'b1;
        expect_ev(2, 12'd1, 3551);
        press(3532, 17);

        // reset while ON clears everything immediately
        wait_cyc(3700);
        expect_ev(2, 12'd0, 3700); expect_ev(3, 12'd0, 3700);
        reset_n = 1'b0;
        #1;
        chk("async_rst1_coin_out",  {31'd0, coin_out},  32'd0);
        chk("async_rst1_coin_pend", {28'd0, coin_pend}, 32'd0);
        wait_cyc(3710); reset_n = 1'b1;

        // pend = 1, new edge on the dequeue tick: pend stays 1, pulse starts
        expect_ev(3, 12'd1, 3879);
        press(3860, 17);
        expect_ev(2, 12'd1, 3951);
        press(3932, 17);
        expect_ev(3, 12'd2, 4019);
        press(4000, 17);

        // reset during ON with pend = 2; nothing follows after release
        wait_cyc(4100);
        expect_ev(2, 12'd0, 4100); expect_ev(3, 12'd0, 4100);
        reset_n = 1'b0;
        #1;
        chk("async_rst2_coin_out",  {31'd0, coin_out},  32'd0);
        chk("async_rst2_coin_pend", {28'd0, coin_pend}, 32'd0);
        wait_cyc(4110); reset_n = 1'b1;
        wait_cyc(4500);

        chk("events_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
